// File: rtl/ddc_ctrl_pkg.sv
// Shared encodings and helpers for the downconverter controller.
// State values are exposed on o_state, so they are pinned here.
package ddc_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_PRIME = S_PRIME,
        ST_RUN   = S_RUN,
        ST_DRAIN = S_DRAIN
    } ddc_state_e;

    // Bits needed to hold the values 0..n, never less than one.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ddc_sample_pairer.sv
// Packs consecutive real ADC samples into (held, current) pairs
// for the downconverter input; clear drops any half pair.
module ddc_sample_pairer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_even_data,
    output logic [WIDTH-1:0] o_odd_data,
    output logic             o_valid
);

    logic             phase_q, phase_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [WIDTH-1:0] even_q, even_d;
    logic [WIDTH-1:0] odd_q, odd_d;
    logic             valid_q, valid_d;
    logic             take;

    assign take = !i_clear && i_enable && i_valid;

    always_comb begin
        phase_d = phase_q;
        held_d  = held_q;
        even_d  = even_q;
        odd_d   = odd_q;
        valid_d = 1'b0;
        unique case (1'b1)
            i_clear: begin
                phase_d = 1'b0;
            end
            take && !phase_q: begin
                held_d  = i_data;
                phase_d = 1'b1;
            end
            take && phase_q: begin
                even_d  = held_q;
                odd_d   = i_data;
                valid_d = 1'b1;
                phase_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase_q <= 1'b0;
            held_q  <= '0;
            even_q  <= '0;
            odd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            held_q  <= held_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            valid_q <= valid_d;
        end
    end

    assign o_even_data = even_q;
    assign o_odd_data  = odd_q;
    assign o_valid     = valid_q;

endmodule

// File: rtl/downconverter_ctrl.sv
// Burst controller around a digital downconverter: feeds ADC pairs,
// discards warm-up output, forwards a counted burst, then drains.
module downconverter_ctrl
    import ddc_ctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_W     = 16,
    parameter int WARMUP    = 64,
    parameter int DRAIN_CYC = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_burst_len,
    input  logic [WIDTH-1:0] i_adc_data,
    input  logic             i_adc_valid,
    output logic [WIDTH-1:0] o_ddc_inph_data,
    output logic [WIDTH-1:0] o_ddc_inph_delay_data,
    output logic             o_ddc_valid,
    input  logic [WIDTH-1:0] i_ddc_inph_data,
    input  logic [WIDTH-1:0] i_ddc_quad_data,
    input  logic             i_ddc_valid,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_out_count
);

    localparam int WW = cnt_bits(WARMUP);
    localparam int DW = cnt_bits(DRAIN_CYC);
    localparam logic [WW-1:0] WARM_LAST =
        (WARMUP > 0) ? WW'(WARMUP - 1) : '0;
    localparam logic [DW-1:0] DRAIN_LAST =
        (DRAIN_CYC > 0) ? DW'(DRAIN_CYC - 1) : '0;

    ddc_state_e       state_q, state_d;
    logic [CNT_W-1:0] blen_q, blen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [WIDTH-1:0] inph_q, inph_d;
    logic [WIDTH-1:0] quad_q, quad_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             pair_en;
    logic             pair_clr;

    assign pair_en  = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign pair_clr = !pair_en;

    ddc_sample_pairer #(
        .WIDTH(WIDTH)
    ) u_pairer (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_enable    (pair_en),
        .i_clear     (pair_clr),
        .i_data      (i_adc_data),
        .i_valid     (i_adc_valid),
        .o_even_data (o_ddc_inph_data),
        .o_odd_data  (o_ddc_inph_delay_data),
        .o_valid     (o_ddc_valid)
    );

    always_comb begin
        state_d = state_q;
        blen_d  = blen_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        drain_d = drain_q;
        inph_d  = inph_q;
        quad_d  = quad_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    blen_d  = i_burst_len;
                    cnt_d   = '0;
                    warm_d  = '0;
                    drain_d = '0;
                    state_d = (WARMUP == 0) ? ST_RUN : ST_PRIME;
                end
            end
            ST_PRIME: begin
                drain_d = '0;
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end else if (i_ddc_valid) begin
                    warm_d = warm_q + WW'(1);
                    if (warm_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                drain_d = '0;
                // A beat coincident with stop still goes out.
                if (i_ddc_valid) begin
                    valid_d = 1'b1;
                    inph_d  = i_ddc_inph_data;
                    quad_d  = i_ddc_quad_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if ((blen_q != '0) && (cnt_d == blen_q)) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            blen_q  <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
            drain_q <= '0;
            inph_q  <= '0;
            quad_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blen_q  <= blen_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            drain_q <= drain_d;
            inph_q  <= inph_d;
            quad_q  <= quad_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_inph_data = inph_q;
    assign o_quad_data = quad_q;
    assign o_valid     = valid_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_state     = state_q;
    assign o_out_count = cnt_q;

endmodule

// File: tb/tb_downconverter_ctrl.sv
// Bench for downconverter_ctrl: two instances (warm-up 4 and 0)
// checked against a behavioural model of the burst rules.
module tb_downconverter_ctrl;

    localparam int W   = 16;
    localparam int CW  = 4;
    localparam int WUA = 4;
    localparam int WUB = 0;
    localparam int DC  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic startA = 1'b0, stopA = 1'b0;
    logic startB = 1'b0, stopB = 1'b0;
    logic [CW-1:0] blenA = '0, blenB = '0;
    logic [W-1:0] adc_d = '0, ddc_i = '0, ddc_q = '0;
    logic adc_v = 1'b0, ddc_v = 1'b0;

    logic [W-1:0] A_ddc_i, A_ddc_dly, A_i, A_q;
    logic A_ddc_v, A_v, A_busy, A_done;
    logic [1:0] A_state;
    logic [CW-1:0] A_cnt;
    logic [W-1:0] B_ddc_i, B_ddc_dly, B_i, B_q;
    logic B_ddc_v, B_v, B_busy, B_done;
    logic [1:0] B_state;
    logic [CW-1:0] B_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model, index 0 = instance A, 1 = instance B
    int m_st[2], m_w[2], m_cnt[2], m_bl[2], m_d[2], m_ph[2];
    int m_held[2], m_da[2], m_db[2], m_oi[2], m_oq[2];
    bit m_dv[2], m_v[2], m_done[2];

    always #5 clk = ~clk;

    downconverter_ctrl #(
        .WIDTH(W), .CNT_W(CW), .WARMUP(WUA), .DRAIN_CYC(DC)
    ) u_a (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_start(startA), .i_stop(stopA), .i_burst_len(blenA),
        .i_adc_data(adc_d), .i_adc_valid(adc_v),
        .o_ddc_inph_data(A_ddc_i), .o_ddc_inph_delay_data(A_ddc_dly),
        .o_ddc_valid(A_ddc_v),
        .i_ddc_inph_data(ddc_i), .i_ddc_quad_data(ddc_q),
        .i_ddc_valid(ddc_v),
        .o_inph_data(A_i), .o_quad_data(A_q), .o_valid(A_v),
        .o_busy(A_busy), .o_done(A_done), .o_state(A_state),
        .o_out_count(A_cnt)
    );

    downconverter_ctrl #(
        .WIDTH(W), .CNT_W(CW), .WARMUP(WUB), .DRAIN_CYC(DC)
    ) u_b (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_start(startB), .i_stop(stopB), .i_burst_len(blenB),
        .i_adc_data(adc_d), .i_adc_valid(adc_v),
        .o_ddc_inph_data(B_ddc_i), .o_ddc_inph_delay_data(B_ddc_dly),
        .o_ddc_valid(B_ddc_v),
        .i_ddc_inph_data(ddc_i), .i_ddc_quad_data(ddc_q),
        .i_ddc_valid(ddc_v),
        .o_inph_data(B_i), .o_quad_data(B_q), .o_valid(B_v),
        .o_busy(B_busy), .o_done(B_done), .o_state(B_state),
        .o_out_count(B_cnt)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_w[k] = 0; m_cnt[k] = 0; m_bl[k] = 0;
            m_d[k] = 0; m_ph[k] = 0; m_held[k] = 0; m_da[k] = 0;
            m_db[k] = 0; m_oi[k] = 0; m_oq[k] = 0;
            m_dv[k] = 0; m_v[k] = 0; m_done[k] = 0;
        end
    endtask

    // States: 0 idle, 1 prime, 2 run, 3 drain.
    task automatic model_edge(input int k);
        int s, ns, wu, bl;
        logic st, sp;
        s  = m_st[k];
        ns = s;
        wu = (k == 0) ? WUA : WUB;
        st = (k == 0) ? startA : startB;
        sp = (k == 0) ? stopA : stopB;
        bl = (k == 0) ? int'(blenA) : int'(blenB);
        m_dv[k] = 0; m_v[k] = 0; m_done[k] = 0;
        if ((s == 1 || s == 2) && adc_v) begin
            if (m_ph[k] == 0) begin
                m_held[k] = int'(adc_d); m_ph[k] = 1;
            end else begin
                m_da[k] = m_held[k]; m_db[k] = int'(adc_d);
                m_dv[k] = 1; m_ph[k] = 0;
            end
        end else if (s == 0 || s == 3) begin
            m_ph[k] = 0;
        end
        case (s)
            0: if (st && !sp) begin
                m_bl[k] = bl; m_w[k] = 0; m_cnt[k] = 0;
                ns = (wu == 0) ? 2 : 1;
            end
            1: if (sp) ns = 3;
               else if (ddc_v) begin
                   m_w[k]++;
                   if (m_w[k] == wu) ns = 2;
               end
            2: begin
                if (ddc_v) begin
                    m_v[k] = 1; m_oi[k] = int'(ddc_i); m_oq[k] = int'(ddc_q);
                    m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
                    if (m_bl[k] != 0 && m_cnt[k] == m_bl[k]) ns = 3;
                end
                if (sp) ns = 3;
            end
            default: begin
                m_d[k]++;
                if (m_d[k] == DC) begin ns = 0; m_done[k] = 1; end
            end
        endcase
        if (ns == 3 && s != 3) m_d[k] = 0;
        m_st[k] = ns;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin model_edge(0); model_edge(1); end
        #1;
    endtask

    task automatic test_reset();
        logic [73:0] va, vb;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        va = {A_ddc_i, A_ddc_dly, A_ddc_v, A_i, A_q, A_v, A_busy, A_done, A_state, A_cnt};
        vb = {B_ddc_i, B_ddc_dly, B_ddc_v, B_i, B_q, B_v, B_busy, B_done, B_state, B_cnt};
        n_cmp++;
        if (va !== '0) begin n_err++; $display("FAIL reset_a got %h want 0", va); end
        n_cmp++;
        if (vb !== '0) begin n_err++; $display("FAIL reset_b got %h want 0", vb); end
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({A_state, A_busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_release got %b want 000", {A_state, A_busy});
        end
    endtask

    task automatic test_burst();
        int ramp, nv, nd, t_dr, t_dn, fi, pa, pb;
        bit gotp, fin;
        logic [9:0] g, e;
        logic [63:0] gd, ed;
        logic [W-1:0] bq[$];
        ramp = 0; nv = 0; nd = 0; t_dr = -1; t_dn = -1;
        fi = -1; pa = -1; pb = -1; gotp = 0; fin = 0;
        blenA = 4'd3; startA = 1'b1; adc_v = 1'b0; ddc_v = 1'b0;
        tick();
        startA = 1'b0;
        n_cmp++;
        if (A_state !== 2'd1) begin n_err++; $display("FAIL burst_prime got %0d want 1", A_state); end
        for (int c = 0; c < 100 && !fin; c++) begin
            adc_v = 1'b1; adc_d = W'(ramp); ramp++;
            ddc_v = 1'($urandom_range(0, 1));
            ddc_i = W'($urandom); ddc_q = W'($urandom);
            if (ddc_v) bq.push_back(ddc_i);
            tick();
            g = {A_state, A_busy, A_done, A_v, A_ddc_v, A_cnt};
            e = {2'(m_st[0]), m_st[0] != 0, m_done[0], m_v[0], m_dv[0], 4'(m_cnt[0])};
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL burst_ctrl t=%0t got %b want %b", $time, g, e); end
            gd = {A_i, A_q, A_ddc_i, A_ddc_dly};
            ed = {W'(m_oi[0]), W'(m_oq[0]), W'(m_da[0]), W'(m_db[0])};
            n_cmp++;
            if (gd !== ed) begin n_err++; $display("FAIL burst_data t=%0t got %h want %h", $time, gd, ed); end
            if (A_ddc_v && !gotp) begin gotp = 1; pa = int'(A_ddc_i); pb = int'(A_ddc_dly); end
            if (A_v) begin if (nv == 0) fi = int'(A_i); nv++; end
            if (A_state == 2'd3 && t_dr < 0) t_dr = c;
            if (A_done) begin nd++; t_dn = c; fin = 1; end
        end
        adc_v = 1'b0; ddc_v = 1'b0;
        n_cmp++;
        if (!fin) begin n_err++; $display("FAIL burst_timeout got no done want done"); end
        n_cmp++;
        if (nv != 3) begin n_err++; $display("FAIL burst_beats got %0d want 3", nv); end
        n_cmp++;
        if (A_cnt !== 4'd3) begin n_err++; $display("FAIL burst_count got %0d want 3", A_cnt); end
        n_cmp++;
        if (pa != 0 || pb != 1) begin n_err++; $display("FAIL burst_pair got (%0d,%0d) want (0,1)", pa, pb); end
        n_cmp++;
        if (bq.size() < 5 || fi != int'(bq[4])) begin
            n_err++; $display("FAIL burst_warmup got first %0d want fifth beat", fi);
        end
        n_cmp++;
        if (t_dn - t_dr != DC) begin n_err++; $display("FAIL burst_drain got %0d want %0d", t_dn - t_dr, DC); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (A_done) nd++;
        end
        n_cmp++;
        if (nd != 1) begin n_err++; $display("FAIL burst_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_continuous();
        int nv, prev;
        bit run_seen, wrapped, fin;
        nv = 0; prev = 0; run_seen = 0; wrapped = 0; fin = 0;
        blenA = 4'd0; startA = 1'b1;
        tick();
        startA = 1'b0;
        for (int c = 0; c < 300 && nv < 20; c++) begin
            adc_v = 1'($urandom_range(0, 1));
            adc_d = W'($urandom);
            ddc_v = ($urandom_range(0, 3) != 0);
            ddc_i = W'($urandom); ddc_q = W'($urandom);
            tick();
            if (A_v) nv++;
            if (prev == 15 && A_cnt == 4'd0) wrapped = 1;
            prev = int'(A_cnt);
            n_cmp++;
            if (int'(A_cnt) != nv % 16) begin n_err++; $display("FAIL cont_count got %0d want %0d", A_cnt, nv % 16); end
            if (A_state == 2'd2) run_seen = 1;
            if (run_seen) begin
                n_cmp++;
                if (A_state !== 2'd2) begin n_err++; $display("FAIL cont_state got %0d want 2", A_state); end
            end
        end
        n_cmp++;
        if (nv != 20) begin n_err++; $display("FAIL cont_timeout got %0d beats want 20", nv); end
        n_cmp++;
        if (!wrapped) begin n_err++; $display("FAIL cont_wrap got no 15->0 want wrap"); end
        ddc_v = 1'b0; adc_v = 1'b0; stopA = 1'b1;
        tick();
        stopA = 1'b0;
        n_cmp++;
        if (A_state !== 2'd3) begin n_err++; $display("FAIL cont_stop got %0d want 3", A_state); end
        for (int c = 0; c < 20 && !fin; c++) begin
            tick();
            if (A_done) fin = 1;
        end
        n_cmp++;
        if (!fin || A_cnt !== 4'd4) begin
            n_err++; $display("FAIL cont_end got done=%0d cnt=%0d want done=1 cnt=4", fin, A_cnt);
        end
    endtask

    task automatic test_stop_mid_pair();
        bit ready, fin;
        logic [W-1:0] di, dq;
        ready = 0; fin = 0;
        blenA = 4'd0; startA = 1'b1;
        tick();
        startA = 1'b0;
        for (int c = 0; c < 60 && !ready; c++) begin
            adc_v = 1'b1; adc_d = W'($urandom);
            ddc_v = 1'($urandom_range(0, 1));
            ddc_i = W'($urandom); ddc_q = W'($urandom);
            tick();
            ready = (m_st[0] == 2 && m_ph[0] == 0 && c > 8);
        end
        n_cmp++;
        if (!ready) begin n_err++; $display("FAIL midpair_setup got state %0d want 2", A_state); end
        di = W'($urandom); dq = W'($urandom);
        adc_v = 1'b1; adc_d = W'($urandom);
        ddc_v = 1'b1; ddc_i = di; ddc_q = dq; stopA = 1'b1;
        tick();
        stopA = 1'b0; ddc_v = 1'b0;
        n_cmp++;
        if ({A_state, A_v, A_ddc_v} !== {2'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL midpair_stop got %b want 11_1_0", {A_state, A_v, A_ddc_v});
        end
        n_cmp++;
        if ({A_i, A_q} !== {di, dq}) begin
            n_err++; $display("FAIL midpair_beat got %h want %h", {A_i, A_q}, {di, dq});
        end
        for (int c = 0; c < 20 && !fin; c++) begin
            adc_v = 1'b1; adc_d = W'($urandom);
            tick();
            if (A_done) fin = 1;
            n_cmp++;
            if (A_ddc_v !== 1'b0 || A_v !== 1'b0) begin
                n_err++; $display("FAIL midpair_drain got ddc_v=%b v=%b want 0 0", A_ddc_v, A_v);
            end
        end
        adc_v = 1'b0;
        n_cmp++;
        if (!fin || A_state !== 2'd0) begin
            n_err++; $display("FAIL midpair_done got done=%0d state=%0d want 1 0", fin, A_state);
        end
    endtask

    task automatic test_start_stop_together();
        startA = 1'b1; stopA = 1'b1; blenA = 4'd2;
        tick();
        startA = 1'b0; stopA = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({A_state, A_busy} !== 3'b000) begin
                n_err++; $display("FAIL startstop got %b want 000", {A_state, A_busy});
            end
            tick();
        end
    endtask

    task automatic test_reset_in_prime();
        logic [73:0] va;
        bit sawdone;
        sawdone = 0;
        blenA = 4'd3; startA = 1'b1;
        tick();
        startA = 1'b0;
        adc_v = 1'b1; adc_d = 16'h1234;
        tick();
        adc_d = 16'h5678;
        tick();
        adc_v = 1'b0;
        n_cmp++;
        if (A_state !== 2'd1 || A_ddc_v !== 1'b1) begin
            n_err++; $display("FAIL rstprime_setup got state=%0d dv=%b want 1 1", A_state, A_ddc_v);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        va = {A_ddc_i, A_ddc_dly, A_ddc_v, A_i, A_q, A_v, A_busy, A_done, A_state, A_cnt};
        n_cmp++;
        if (va !== '0) begin n_err++; $display("FAIL rstprime_clear got %h want 0", va); end
        #2 rst_n = 1'b1;
        for (int c = 0; c < DC + 3; c++) begin
            tick();
            if (A_done || A_state != 2'd0) sawdone = 1;
        end
        n_cmp++;
        if (sawdone) begin n_err++; $display("FAIL rstprime_nodone got activity want idle"); end
        test_burst();
    endtask

    task automatic test_warmup_zero();
        logic [W-1:0] d0, q0;
        bit fin;
        fin = 0;
        adc_v = 1'b0; ddc_v = 1'b0;
        blenB = 4'd2; startB = 1'b1;
        tick();
        startB = 1'b0;
        n_cmp++;
        if ({B_state, B_busy} !== {2'd2, 1'b1}) begin
            n_err++; $display("FAIL wu0_run got %b want 101", {B_state, B_busy});
        end
        d0 = W'($urandom); q0 = W'($urandom);
        ddc_v = 1'b1; ddc_i = d0; ddc_q = q0;
        tick();
        n_cmp++;
        if ({B_v, B_i, B_q, B_cnt} !== {1'b1, d0, q0, 4'd1}) begin
            n_err++; $display("FAIL wu0_first got %h want %h", {B_v, B_i, B_q, B_cnt}, {1'b1, d0, q0, 4'd1});
        end
        ddc_i = W'($urandom);
        tick();
        ddc_v = 1'b0;
        n_cmp++;
        if ({B_state, B_v, B_cnt} !== {2'd3, 1'b1, 4'd2}) begin
            n_err++; $display("FAIL wu0_last got %b want 11_1_0010", {B_state, B_v, B_cnt});
        end
        for (int c = 0; c < 20 && !fin; c++) begin
            tick();
            if (B_done) fin = 1;
        end
        n_cmp++;
        if (!fin || B_cnt !== 4'd2) begin
            n_err++; $display("FAIL wu0_done got done=%0d cnt=%0d want 1 2", fin, B_cnt);
        end
    endtask

    task automatic test_random();
        logic [9:0] g, e;
        logic [63:0] gd, ed;
        for (int c = 0; c < 600; c++) begin
            startA = ($urandom_range(0, 7) == 0);
            stopA  = ($urandom_range(0, 39) == 0);
            blenA  = CW'($urandom_range(0, 7));
            adc_v  = 1'($urandom_range(0, 1));
            adc_d  = W'($urandom);
            ddc_v  = 1'($urandom_range(0, 1));
            ddc_i  = W'($urandom); ddc_q = W'($urandom);
            tick();
            g = {A_state, A_busy, A_done, A_v, A_ddc_v, A_cnt};
            e = {2'(m_st[0]), m_st[0] != 0, m_done[0], m_v[0], m_dv[0], 4'(m_cnt[0])};
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL rand_ctrl t=%0t got %b want %b", $time, g, e); end
            gd = {A_i, A_q, A_ddc_i, A_ddc_dly};
            ed = {W'(m_oi[0]), W'(m_oq[0]), W'(m_da[0]), W'(m_db[0])};
            n_cmp++;
            if (gd !== ed) begin n_err++; $display("FAIL rand_data t=%0t got %h want %h", $time, gd, ed); end
        end
        startA = 1'b0; stopA = 1'b0; adc_v = 1'b0; ddc_v = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_burst();
        test_continuous();
        test_stop_mid_pair();
        test_start_stop_together();
        test_reset_in_prime();
        test_warmup_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/downconverter_ctrl.md
DOWNCONVERTER_CTRL -- requirements
Module: downconverter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width of the ADC and downconverter I/Q words.
REQ-002 SHALL have parameter CNT_W, default 16, width of the burst-length and output counters.
REQ-003 SHALL have parameter WARMUP, default 64, the number of downconverter output samples discarded after start.
REQ-004 SHALL have parameter DRAIN_CYC, default 32, the idle cycles waited after feeding stops.
REQ-005 SHALL have port i_clock, input, 1, the single clock for all logic.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports i_start and i_stop, input, 1 each, single-cycle command pulses.
REQ-008 SHALL have port i_burst_len, input, CNT_W, the output samples per burst, where 0 means continuous.
REQ-009 SHALL have ports i_adc_data (input, WIDTH, real ADC sample) and i_adc_valid (input, 1, sample qualifier).
REQ-010 SHALL have ports o_ddc_inph_data, o_ddc_inph_delay_data (output, WIDTH each) and o_ddc_valid (output, 1), which drive the downconverter input.
REQ-011 SHALL have ports i_ddc_inph_data, i_ddc_quad_data (input, WIDTH each) and i_ddc_valid (input, 1), carrying the downconverter output.
REQ-012 SHALL have ports o_inph_data, o_quad_data (output, WIDTH each) and o_valid (output, 1), carrying the gated baseband output.
REQ-013 SHALL have ports o_busy (output, 1, high when not IDLE), o_done (output, 1, one-cycle pulse at burst end), o_state (output, 2, current state) and o_out_count (output, CNT_W, samples forwarded).

Function
REQ-014 SHALL implement a state machine with four states, IDLE=0, PRIME=1, RUN=2 and DRAIN=3, exposed on o_state.
REQ-015 SHALL, in IDLE, ignore i_adc_valid, hold o_ddc_valid=0 and o_valid=0, and keep the pair phase cleared.
REQ-016 SHALL, when i_start=1 and i_stop=0 in IDLE, enter PRIME on the next cycle, latch i_burst_len, and clear the warm-up counter and o_out_count.
REQ-017 SHALL ignore i_start outside IDLE, and SHALL stay in IDLE when i_stop and i_start are asserted together in IDLE.
REQ-018 SHALL, in PRIME and RUN, pack ADC samples in pairs: the even-phase sample is held; on the odd-phase sample, the next cycle drives o_ddc_inph_data=held, o_ddc_inph_delay_data=current and o_ddc_valid=1 for one cycle.
REQ-019 SHALL keep o_ddc_valid=0 on every cycle without a completed pair, and SHALL hold the o_ddc data outputs between pairs.
REQ-020 SHALL, in PRIME, count i_ddc_valid beats without forwarding them, and SHALL enter RUN on the cycle after beat WARMUP, or directly from IDLE on start when WARMUP=0.
REQ-021 SHALL, in RUN, register each i_ddc_valid beat to o_inph_data, o_quad_data and o_valid=1 with 1-cycle latency, and SHALL increment o_out_count per beat.
REQ-022 SHALL, in RUN with a latched burst length N≠0, forward exactly N beats and then enter DRAIN on the cycle after the Nth beat is presented, with later beats suppressed.
REQ-023 SHALL, in continuous mode (N=0), let o_out_count wrap modulo 2^CNT_W without leaving RUN.
REQ-024 SHALL, on i_stop in PRIME or RUN, enter DRAIN on the next cycle; a beat coincident with i_stop in RUN is still forwarded.
REQ-025 SHALL, in DRAIN, hold o_ddc_valid=0, discard any half pair, suppress o_valid, count DRAIN_CYC cycles, then enter IDLE with o_done=1 for exactly that one cycle.
REQ-026 SHALL keep o_out_count stable from the end of RUN until the next accepted start.

Reset
REQ-027 SHALL, while i_reset_n=0, asynchronously force state=IDLE and clear to 0: all o_ddc_* outputs, o_inph_data, o_quad_data, o_valid, o_busy, o_done, o_out_count, all counters and the pair phase.
REQ-028 SHALL release reset synchronously to i_clock; a reset asserted mid-burst aborts the burst with no o_done pulse.

Structure
REQ-029 SHALL take its state enum typedef and state encodings from a shared package, ddc_ctrl_pkg.
REQ-030 SHALL implement the sample packing as one sub-module, ddc_sample_pairer, with enable and clear inputs.

Verification
REQ-031 SHALL be verified with WARMUP=4, N=3 and continuous ADC ramp 0,1,2,…: the DDC sees pairs (0,1),(2,3),…; the first 4 i_ddc_valid beats are dropped; exactly 3 o_valid beats follow; o_done pulses DRAIN_CYC cycles later; o_out_count=3.
REQ-032 SHALL be verified with N=0 and CNT_W=4 over 20 beats: o_out_count wraps 15→0 and the state stays RUN.
REQ-033 SHALL be verified with i_stop asserted mid-pair in RUN: the half pair produces no o_ddc_valid, the coincident beat is forwarded, and DRAIN→IDLE is followed by o_done.
REQ-034 SHALL be verified with i_start and i_stop pulsed together in IDLE: the state stays 0 and o_busy stays 0.
REQ-035 SHALL be verified with i_reset_n asserted in PRIME: all outputs are immediately 0, state=IDLE, no o_done pulse, and a subsequent start behaves as in REQ-031.
REQ-036 SHALL be verified with WARMUP=0: the state goes IDLE→RUN directly on start and the first DDC beat is forwarded.
